// File: rtl/regfile_32x32.sv
// 31x32-bit register file (r0 hardwired to zero) exposing all registers flat, plus a commit counter.
// Optional macro REGFILE_WR_BYPASS_EN forwards the in-flight write onto regs_flat in the write cycle.
module regfile_32x32 #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [4:0]         waddr,
  input  logic [DW-1:0]      wdata,
  output logic [NREG*DW-1:0] regs_flat,
  output logic [31:0]        wr_cnt,
  output logic [4:0]         last_waddr
);

  localparam int unsigned AW = $clog2(NREG);

  logic [DW-1:0] regs_q [1:NREG-1];
  logic [DW-1:0] regs_d [1:NREG-1];
  logic [31:0]   wr_cnt_q, wr_cnt_d;
  logic [4:0]    last_waddr_q, last_waddr_d;
  logic          commit;

  // A write to r0 is dropped entirely: no storage, count or last-address update.
  assign commit = !rst && we && (waddr != '0);

  always_comb begin
    for (int unsigned i = 1; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (waddr == AW'(i))) begin
        regs_d[i] = wdata;
      end
    end
    wr_cnt_d     = wr_cnt_q;
    last_waddr_d = last_waddr_q;
    if (commit) begin
      wr_cnt_d     = wr_cnt_q + 32'd1;
      last_waddr_d = waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q     <= '0;
      last_waddr_q <= '0;
    end else begin
      regs_q       <= regs_d;
      wr_cnt_q     <= wr_cnt_d;
      last_waddr_q <= last_waddr_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      regs_flat[i*DW +: DW] = regs_q[i];
`ifdef REGFILE_WR_BYPASS_EN
      if (commit && (waddr == AW'(i))) begin
        regs_flat[i*DW +: DW] = wdata;
      end
`endif
    end
  end

  assign wr_cnt     = wr_cnt_q;
  assign last_waddr = last_waddr_q;

endmodule

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32: vector table plus scoreboard of full-state expectations.
// Honours REGFILE_WR_BYPASS_EN for the same-cycle slice expectations.
module tb_regfile_32x32;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, we;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic [1023:0] regs_flat;
  logic [31:0]   wr_cnt;
  logic [4:0]    last_waddr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_32x32 #(.DW(32), .NREG(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .regs_flat (regs_flat),
    .wr_cnt    (wr_cnt),
    .last_waddr(last_waddr)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int unsigned idx;
    logic [31:0] val;
    logic [31:0] cnt;
    logic [4:0]  last;
  } vec_t;

  typedef struct {
    logic [1023:0] flat;
    logic [31:0]   cnt;
    logic [4:0]    last;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m [32];
  logic [31:0] mcnt;
  logic [4:0]  mlast;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkflat(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1023:0] model_flat();
    logic [1023:0] f;
    for (int i = 0; i < 32; i++) f[i*32 +: 32] = m[i];
    return f;
  endfunction

  // Drive one cycle, check the same-cycle slice, predict and score the post-edge state.
  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] pre;
    int unsigned ai;
    ai = a;
    @(negedge clk);
    rst = r; we = w; waddr = a; wdata = d;
    #1;
    if (!r) begin
      pre = (BYP && w && (a != 5'd0)) ? d : m[ai];
      chk32("pre_edge_slice", regs_flat[ai*32 +: 32], pre);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      mcnt  = 32'h0;
      mlast = 5'd0;
    end else if (w && (a != 5'd0)) begin
      m[ai] = d;
      mcnt  = mcnt + 32'd1;
      mlast = a;
    end
    e.flat = model_flat();
    e.cnt  = mcnt;
    e.last = mlast;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chkflat("regs_flat", regs_flat, e.flat);
      chk32("wr_cnt", wr_cnt, e.cnt);
      chk32("last_waddr", {27'd0, last_waddr}, {27'd0, e.last});
    end
  endtask

  vec_t vecs[9];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    mcnt = '0; mlast = '0;

    vecs[0] = '{1'b1, 1'b0, 5'd0,  32'h0,        5,  32'h0,        32'd0, 5'd0};
    vecs[1] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5,  32'hDEADBEEF, 32'd1, 5'd5};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  32'h12345678, 0,  32'h0,        32'd1, 5'd5};
    vecs[3] = '{1'b0, 1'b0, 5'd9,  32'h00001111, 9,  32'h0,        32'd1, 5'd5};
    vecs[4] = '{1'b0, 1'b1, 5'd7,  32'hA5A5A5A5, 7,  32'hA5A5A5A5, 32'd2, 5'd7};
    vecs[5] = '{1'b0, 1'b1, 5'd7,  32'h0BADF00D, 7,  32'h0BADF00D, 32'd3, 5'd7};
    vecs[6] = '{1'b0, 1'b1, 5'd31, 32'hCAFEBABE, 31, 32'hCAFEBABE, 32'd4, 5'd31};
    vecs[7] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 31, 32'h0,        32'd0, 5'd0};
    vecs[8] = '{1'b0, 1'b1, 5'd1,  32'h00000001, 1,  32'h00000001, 32'd1, 5'd1};

    for (int v = 0; v < 9; v++) begin
      step(vecs[v].rst, vecs[v].we, vecs[v].waddr, vecs[v].wdata);
      chk32($sformatf("vec%0d_slice", v), regs_flat[vecs[v].idx*32 +: 32], vecs[v].val);
      chk32($sformatf("vec%0d_cnt", v), wr_cnt, vecs[v].cnt);
      chk32($sformatf("vec%0d_last", v), {27'd0, last_waddr}, {27'd0, vecs[v].last});
    end

    // Fill every register on consecutive cycles.
    step(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), 32'(i + 1));
    for (int n = 0; n < 32; n++)
      chk32($sformatf("fill_slice%0d", n), regs_flat[n*32 +: 32], (n == 0) ? 32'h0 : 32'(n + 1));
    chk32("fill_cnt", wr_cnt, 32'd31);
    chk32("fill_last", {27'd0, last_waddr}, 32'd31);

    // Unknown address/data with we low must not disturb state.
    @(negedge clk);
    we = 1'b0; waddr = 'x; wdata = 'x;
    @(posedge clk);
    #1;
    chkflat("idle_x_flat", regs_flat, model_flat());
    chk32("idle_x_cnt", wr_cnt, 32'd31);

    // Reset in the middle of a write burst.
    step(1'b0, 1'b1, 5'd3, 32'h33333333);
    step(1'b0, 1'b1, 5'd4, 32'h44444444);
    step(1'b1, 1'b1, 5'd3, 32'h55555555);
    chkflat("midreset_flat", regs_flat, 1024'h0);
    chk32("midreset_cnt", wr_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_32x32.md
REGFILE_32X32 -- requirements
Module: regfile_32x32

Interface
REQ-001 SHALL have parameter DW, default 32, the register data width; only 32 is supported.
REQ-002 SHALL have parameter NREG, default 32, the register count; only 32 is supported, giving a 5-bit address.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port we, input, 1 bit: write enable, sampled at the rising clk edge.
REQ-006 SHALL have port waddr, input, 5 bits: destination register index.
REQ-007 SHALL have port wdata, input, 32 bits: write data.
REQ-008 SHALL have port regs_flat, output, 1024 bits: all 32 registers, register N at bits [32N+31:32N], feeding the downstream 32:1 read-select stage.
REQ-009 SHALL have port wr_cnt, output, 32 bits: count of committed writes.
REQ-010 SHALL have port last_waddr, output, 5 bits: index of the most recent committed write.

Function
REQ-011 SHALL hold 31 storage registers, r1..r31, each 32 bits; r0 SHALL be no storage and SHALL read 32'h0 at all times.
REQ-012 SHALL commit a write at the rising clk edge when rst=0, we=1 and waddr!=0: r[waddr] <= wdata; the new value is visible on regs_flat the cycle after the edge, a latency of 1.
REQ-013 SHALL drop a write with we=1 and waddr=0: no storage change, wr_cnt unchanged, last_waddr unchanged.
REQ-014 SHALL hold every register when we=0.
REQ-015 SHALL change only the addressed register on a commit; all other 30 registers hold.
REQ-016 SHALL increment wr_cnt by 1 on each committed write (REQ-012), wrapping from 32'hFFFFFFFF to 0 with no flag.
REQ-017 SHALL load last_waddr <= waddr on each committed write.
REQ-018 SHALL make back-to-back writes to the same address on consecutive cycles leave the second value; each write counts in wr_cnt.
REQ-019 SHALL keep the output free of X: X or Z on inputs while we=0 causes no state change.
REQ-020 SHALL drive regs_flat directly from registers, with no combinational path from the inputs, except as stated in REQ-026.

Reset
REQ-021 SHALL have rst=1 at a rising edge clear r1..r31 to 32'h0, wr_cnt to 0 and last_waddr to 5'd0.
REQ-022 SHALL give rst priority over we: a write presented in the same cycle as rst is discarded.
REQ-023 SHALL show regs_flat = all zero from the cycle after the reset edge.
REQ-024 SHALL have reset asserted mid-sequence abort nothing pending; the block has no multi-cycle state.
REQ-025 SHALL leave outputs undefined before the first reset edge; the bench SHALL reset before checking.

Configuration
REQ-026 SHALL, when REGFILE_WR_BYPASS_EN is defined, drive the regs_flat slice for waddr combinationally with wdata while we=1, waddr!=0 and rst=0, so same-cycle read-after-write is seen downstream; storage timing stays per REQ-012.
REQ-027 SHALL, when REGFILE_WR_BYPASS_EN is not defined, drive regs_flat purely from storage, with a 1-cycle write-to-visible latency.
REQ-028 SHALL, with the macro defined, keep slice 0 at 32'h0 even when waddr=0 and we=1.

Verification
REQ-029 SHALL cover reset, then idle: regs_flat=0, wr_cnt=0 and last_waddr=0 after 1 edge.
REQ-030 SHALL cover we=1, waddr=5, wdata=32'hDEADBEEF for one edge -> slice 5 = 32'hDEADBEEF the next cycle, other slices 0, wr_cnt=1, last_waddr=5.
REQ-031 SHALL cover we=1, waddr=0, wdata=32'h12345678 -> slice 0 stays 0, wr_cnt unchanged, and with the bypass defined slice 0 is still 0 in the write cycle.
REQ-032 SHALL cover rst=1 with we=1, waddr=31, wdata=32'hFFFFFFFF on the same edge -> r31=0 and wr_cnt=0 afterwards.
REQ-033 SHALL cover writes of i+1 to address i for i=1..31 on consecutive cycles -> every slice N = N+1, slice 0 = 0, wr_cnt=31, last_waddr=31.
REQ-034 SHALL cover, with REGFILE_WR_BYPASS_EN defined, we=1, waddr=7, wdata=32'hA5A5A5A5 -> slice 7 = 32'hA5A5A5A5 in the same cycle before the edge; without the macro, the slice holds its old value until after the edge.
